fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 Port list, as name direction width meaning; clock and reset come first:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_wen  in  1  PC advance enable from the hazard unit.
- if_id_wen  in  1  IF/ID write enable from the hazard unit.
- if_id_flush  in  1  bubble the IF/ID register.
- control_hazard  in  1  redirect request.
- branch_target  in  16  redirect address.
- imem_req  out  1  instruction memory request.
- imem_addr  out  16  request address.
- imem_ready  in  1  memory data valid this cycle.
- imem_rdata  in  16  instruction word.
- if_id_instr  out  16  registered instruction.
- if_id_pc_plus2  out  16  registered PC+2 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_stall  out  1  request outstanding and not ready this cycle.
- halted  out  1  fetch stopped on HLT.
REQ-003 imem_addr, if_id_instr and if_id_pc_plus2 SHALL be unsigned 16-bit byte addresses or words; bit 0 of every PC SHALL be 0, and bit 0 of branch_target SHALL be ignored.

Function
REQ-004 State machine: RUN, DROP, HALT.
REQ-005 imem_req SHALL be 1 in RUN and DROP and 0 in HALT. While imem_req=1, imem_addr SHALL equal pc and SHALL stay stable until imem_ready.
REQ-006 Completion: imem_req & imem_ready in the same cycle. Memory latency is unbounded (at least 0 wait cycles).
REQ-007 fetch_stall SHALL be imem_req & ~imem_ready.
REQ-008 RUN, completion, control_hazard=1: pc <= branch_target; the returned word is discarded; state stays RUN.
REQ-009 RUN, completion, control_hazard=0, pc_wen=1, opcode imem_rdata[15:12] != 4'hF: pc <= pc+2. PC+2 wraps modulo 2^16, so 0xFFFE -> 0x0000.
REQ-010 RUN, completion, control_hazard=0, pc_wen=1, opcode 4'hF (HLT): pc holds; state <= HALT; halted becomes 1 the next cycle.
REQ-011 RUN, completion, pc_wen=0, control_hazard=0: pc holds; the word is discarded and refetched.
REQ-012 RUN, no completion, control_hazard=1: redirect register <= branch_target; state <= DROP.
REQ-013 DROP: keep requesting the old pc. On completion: discard the word, pc <= redirect register, state <= RUN. A further control_hazard in DROP SHALL overwrite the redirect register; the latest target wins.
REQ-014 HALT: no requests. control_hazard=1 -> pc <= branch_target, state <= RUN, halted <= 0. Only control_hazard or reset leaves HALT.
REQ-015 IF/ID update priority, evaluated each edge:
- First, if_id_flush=1: instr <= 16'h0000, valid <= 0, pc_plus2 <= 0.
- Otherwise, if_id_wen=0: hold all fields.
- Otherwise, a completion accepted under REQ-009 or REQ-010: instr <= imem_rdata, pc_plus2 <= pc+2, valid <= 1.
- In all other cases: a bubble, encoded as for flush.
REQ-016 A fetched word SHALL reach IF/ID exactly one edge after its completion cycle. For a 0-wait memory, throughput SHALL be one instruction per cycle.
REQ-017 No completed, accepted word SHALL ever be dropped, and no discarded word SHALL ever reach IF/ID with valid=1.

Reset
REQ-018 rst=0 SHALL asynchronously set:
- pc = 0x0000, state = RUN, redirect register = 0x0000.
- if_id_instr = 0, if_id_pc_plus2 = 0, if_id_valid = 0, halted = 0.
REQ-019 imem_req SHALL be 0 while rst=0. The first request (address 0x0000) SHALL issue in the first cycle after rst deasserts.
REQ-020 Reset asserted while a request is outstanding SHALL abandon that request with no IF/ID update; the late imem_ready is ignored.

Verification
REQ-021 0-wait memory returning 0x1234, 0x2345, 0x3456, all enables 1 -> IF/ID valid with pc_plus2 0x0002, 0x0004, 0x0006 on consecutive cycles.
REQ-022 3-wait memory, control_hazard=1 with target 0x0040 in the 2nd wait cycle -> old word discarded, next imem_addr 0x0040, no valid IF/ID entry from the old address.
REQ-023 pc_wen=0 and if_id_wen=0 for 2 cycles at pc 0x0010 -> IF/ID holds; pc stays 0x0010; word refetched and loaded once the stall releases.
REQ-024 Fetch 0xF000 at pc 0x0020 -> IF/ID gets 0xF000 with pc_plus2 0x0022, halted=1, imem_req=0; then control_hazard with target 0x0100 -> RUN and fetches 0x0100.
REQ-025 pc 0xFFFE, 0-wait memory -> next imem_addr 0x0000; if_id_pc_plus2 = 0x0000.
REQ-026 rst pulsed low mid-request at pc 0x0008 -> all outputs at reset values; first imem_addr after release is 0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, redirect/halt handling and the IF/ID register.
// A redirect that arrives mid-request is parked until the in-flight word returns.
module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_wen,
   input  logic        if_id_wen,
   input  logic        if_id_flush,
   input  logic        control_hazard,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic        fetch_stall,
   output logic        halted
);

   typedef enum logic [1:0] {RUN, DROP, HALT} state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] redir;
   logic [15:0] pc_next2;
   logic [15:0] target;
   logic        done;
   logic        accept;
   logic        is_hlt;

   assign target      = {branch_target[15:1], 1'b0};
   assign pc_next2    = pc + 16'd2;
   assign imem_req    = rst & (state != HALT);
   assign imem_addr   = pc;
   assign done        = imem_req & imem_ready;
   assign fetch_stall = imem_req & ~imem_ready;
   assign is_hlt      = (imem_rdata[15:12] == 4'hF);
   assign accept      = (state == RUN) & done
                      & ~control_hazard & pc_wen;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         pc     <= 16'h0000;
         redir  <= 16'h0000;
         halted <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (done) begin
                  if (control_hazard) begin
                     pc <= target;
                  end else if (pc_wen) begin
                     if (is_hlt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                     end else begin
                        pc <= pc_next2;
                     end
                  end
               end else if (control_hazard) begin
                  redir <= target;
                  state <= DROP;
               end
            end
            DROP: begin
               // the newest redirect overrides any parked target
               if (control_hazard)
                  redir <= target;
               if (done) begin
                  pc    <= control_hazard ? target : redir;
                  state <= RUN;
               end
            end
            HALT: begin
               if (control_hazard) begin
                  pc     <= target;
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_id_instr    <= 16'h0000;
         if_id_pc_plus2 <= 16'h0000;
         if_id_valid    <= 1'b0;
      end else if (if_id_flush) begin
         if_id_instr    <= 16'h0000;
         if_id_pc_plus2 <= 16'h0000;
         if_id_valid    <= 1'b0;
      end else if (if_id_wen) begin
         if (accept) begin
            if_id_instr    <= imem_rdata;
            if_id_pc_plus2 <= pc_next2;
            if_id_valid    <= 1'b1;
         end else begin
            if_id_instr    <= 16'h0000;
            if_id_pc_plus2 <= 16'h0000;
            if_id_valid    <= 1'b0;
         end
      end
   end

endmodule
